// File: rtl/jt51_pg_pkg.sv
// Shared constants for the JT51 phase-generator slice: slot geometry,
// register-field selectors and the pipeline stage offsets of the PG.
package jt51_pg_pkg;

    localparam int NSLOT  = 32;
    localparam int NCH    = 8;
    localparam int SLOT_W = 5;
    localparam int CH_W   = 3;
    localparam int OP_W   = 2;

    // Stage offsets, measured in cen cycles from stage I
    localparam int DT1_DLY = 1;
    localparam int RST_DLY = 2;
    localparam int MUL_DLY = 5;

    typedef enum logic [2:0] {
        SEL_KC  = 3'd0,
        SEL_KF  = 3'd1,
        SEL_PMS = 3'd2,
        SEL_MUL = 3'd3,
        SEL_DT1 = 3'd4,
        SEL_DT2 = 3'd5
    } wr_sel_e;

endpackage

// File: rtl/jt51_pg_sched_if.sv
// Register-write and key-on request bus between the CPU front end and the
// PG scheduler.
interface jt51_pg_sched_if;

    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_sel;
    logic [4:0] wr_addr;
    logic [6:0] wr_data;
    logic       kon_valid;
    logic [2:0] kon_ch;
    logic [3:0] kon_ops;

    modport master (
        output wr_valid, wr_sel, wr_addr, wr_data,
        output kon_valid, kon_ch, kon_ops,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_sel, wr_addr, wr_data,
        input  kon_valid, kon_ch, kon_ops,
        output wr_ready
    );

endinterface

// File: rtl/jt51_sh.sv
// Clock-enabled shift register used to carry per-slot values down the PG
// pipeline; drop is the value that entered 'stages' cen cycles ago.
module jt51_sh #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] drop
);

    logic [WIDTH-1:0] bits_q [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) bits_q[i] <= '0;
        end else if (cen) begin
            bits_q[0] <= din;
            for (int i = 1; i < STAGES; i++) bits_q[i] <= bits_q[i-1];
        end
    end

    assign drop = bits_q[STAGES-1];

endmodule

// File: rtl/jt51_pg_sched.sv
// Per-slot parameter register file and slot scheduler for the JT51 PG:
// walks the 32 slots and hands each slot's parameters to the stage that uses them.
module jt51_pg_sched #(
    parameter int NSLOT   = jt51_pg_pkg::NSLOT,
    parameter int MUL_DLY = jt51_pg_pkg::MUL_DLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    jt51_pg_sched_if.slave   bus,
    output logic             zero,
    output logic [4:0]       slot_I,
    output logic [6:0]       kc_I,
    output logic [5:0]       kf_I,
    output logic [2:0]       pms_I,
    output logic [1:0]       dt2_I,
    output logic [2:0]       dt1_II,
    output logic [3:0]       mul_VI,
    output logic             pg_rst_III
);

    import jt51_pg_pkg::*;

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [NSLOT-1:0]  pending_q, pending_d;

    logic [6:0] kc_q  [NCH],   kc_d  [NCH];
    logic [5:0] kf_q  [NCH],   kf_d  [NCH];
    logic [2:0] pms_q [NCH],   pms_d [NCH];
    logic [3:0] mul_q [NSLOT], mul_d [NSLOT];
    logic [2:0] dt1_q [NSLOT], dt1_d [NSLOT];
    logic [1:0] dt2_q [NSLOT], dt2_d [NSLOT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q    <= '0;
            pending_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                kc_q[i]  <= '0;
                kf_q[i]  <= '0;
                pms_q[i] <= '0;
            end
            for (int i = 0; i < NSLOT; i++) begin
                mul_q[i] <= '0;
                dt1_q[i] <= '0;
                dt2_q[i] <= '0;
            end
        end else if (cen) begin
            slot_q    <= slot_d;
            pending_q <= pending_d;
            kc_q      <= kc_d;
            kf_q      <= kf_d;
            pms_q     <= pms_d;
            mul_q     <= mul_d;
            dt1_q     <= dt1_d;
            dt2_q     <= dt2_d;
        end
    end

    // The issue-clear is applied before the key-on update so that a key-on
    // hitting the slot being issued leaves the bit set for the next frame.
    always_comb begin
        slot_d    = slot_q + 5'd1;
        kc_d      = kc_q;
        kf_d      = kf_q;
        pms_d     = pms_q;
        mul_d     = mul_q;
        dt1_d     = dt1_q;
        dt2_d     = dt2_q;
        pending_d = pending_q;
        if (bus.wr_valid) begin
            case (bus.wr_sel)
                SEL_KC:  kc_d[bus.wr_addr[CH_W-1:0]]  = bus.wr_data;
                SEL_KF:  kf_d[bus.wr_addr[CH_W-1:0]]  = bus.wr_data[5:0];
                SEL_PMS: pms_d[bus.wr_addr[CH_W-1:0]] = bus.wr_data[2:0];
                SEL_MUL: mul_d[bus.wr_addr]           = bus.wr_data[3:0];
                SEL_DT1: dt1_d[bus.wr_addr]           = bus.wr_data[2:0];
                SEL_DT2: dt2_d[bus.wr_addr]           = bus.wr_data[1:0];
                default: ;
            endcase
        end
        pending_d[slot_q] = 1'b0;
        if (bus.kon_valid) begin
            for (int op = 0; op < 4; op++)
                pending_d[{op[OP_W-1:0], bus.kon_ch}] = bus.kon_ops[op];
        end
    end

    assign bus.wr_ready = cen & ~rst;
    assign slot_I       = slot_q;
    assign zero         = (slot_q == '0);
    assign kc_I         = kc_q[slot_q[CH_W-1:0]];
    assign kf_I         = kf_q[slot_q[CH_W-1:0]];
    assign pms_I        = pms_q[slot_q[CH_W-1:0]];
    assign dt2_I        = dt2_q[slot_q];

    jt51_sh #(.WIDTH(3), .STAGES(DT1_DLY)) u_dt1_sh (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .din  (dt1_q[slot_q]),
        .drop (dt1_II)
    );

    jt51_sh #(.WIDTH(1), .STAGES(RST_DLY)) u_rst_sh (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .din  (pending_q[slot_q]),
        .drop (pg_rst_III)
    );

    jt51_sh #(.WIDTH(4), .STAGES(MUL_DLY)) u_mul_sh (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .din  (mul_q[slot_q]),
        .drop (mul_VI)
    );

endmodule

// File: tb/tb_jt51_pg_sched.sv
// Directed self-checking bench for jt51_pg_sched; cen runs at half the clock
// rate and outputs are sampled on the falling edge after each cen.
module tb_jt51_pg_sched;

    import jt51_pg_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cen = 1'b0;
    logic       zero;
    logic [4:0] slot_I;
    logic [6:0] kc_I;
    logic [5:0] kf_I;
    logic [2:0] pms_I;
    logic [1:0] dt2_I;
    logic [2:0] dt1_II;
    logic [3:0] mul_VI;
    logic       pg_rst_III;

    int         assertCount = 0;
    int         failCount   = 0;
    logic [4:0] expSlot     = 5'd0;

    jt51_pg_sched_if bus();

    jt51_pg_sched dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .bus        (bus),
        .zero       (zero),
        .slot_I     (slot_I),
        .kc_I       (kc_I),
        .kf_I       (kf_I),
        .pms_I      (pms_I),
        .dt2_I      (dt2_I),
        .dt1_II     (dt1_II),
        .mul_VI     (mul_VI),
        .pg_rst_III (pg_rst_III)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One cen period: inputs are presented for exactly one enabled edge
    task automatic applyStimulus(input logic wv, input logic [2:0] sel,
                                 input logic [4:0] addr, input logic [6:0] data,
                                 input logic kv, input logic [2:0] ch,
                                 input logic [3:0] ops);
        bus.wr_valid  = wv;
        bus.wr_sel    = sel;
        bus.wr_addr   = addr;
        bus.wr_data   = data;
        bus.kon_valid = kv;
        bus.kon_ch    = ch;
        bus.kon_ops   = ops;
        @(negedge clk);
        cen = 1'b1;
        @(negedge clk);
        cen           = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.kon_valid = 1'b0;
        expSlot       = expSlot + 5'd1;
    endtask

    task automatic idleTick();
        applyStimulus(1'b0, 3'd0, 5'd0, 7'd0, 1'b0, 3'd0, 4'd0);
    endtask

    task automatic writeReg(input logic [2:0] sel, input logic [4:0] addr,
                            input logic [6:0] data);
        applyStimulus(1'b1, sel, addr, data, 1'b0, 3'd0, 4'd0);
    endtask

    task automatic konReq(input logic [2:0] ch, input logic [3:0] ops);
        applyStimulus(1'b0, 3'd0, 5'd0, 7'd0, 1'b1, ch, ops);
    endtask

    task automatic advanceTo(input logic [4:0] target);
        while (expSlot != target) idleTick();
    endtask

    function automatic logic [31:0] allOut();
        return {6'd0, kc_I, kf_I, pms_I, dt2_I, dt1_II, mul_VI, pg_rst_III};
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         zeroCount;
        int         pulses;
        logic [4:0] prevSlot;
        logic [4:0] mulSlot;
        logic       isCh3;

        bus.wr_valid  = 1'b0;
        bus.wr_sel    = 3'd0;
        bus.wr_addr   = 5'd0;
        bus.wr_data   = 7'd0;
        bus.kon_valid = 1'b0;
        bus.kon_ch    = 3'd0;
        bus.kon_ops   = 4'd0;

        // Reset state, including wr_ready held low while cen is high
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        cen = 1'b1;
        #1;
        checkOutput("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        checkOutput("rst_slot", 32'(slot_I), 32'd0);
        checkOutput("rst_zero", 32'(zero), 32'd1);
        checkOutput("rst_outputs", allOut(), 32'd0);
        @(negedge clk);
        cen = 1'b0;
        rst = 1'b0;
        expSlot = 5'd0;

        @(negedge clk);
        cen = 1'b1;
        #1 checkOutput("wr_ready_cen", 32'(bus.wr_ready), 32'd1);
        @(negedge clk);
        cen = 1'b0;
        expSlot = expSlot + 5'd1;
        #1 checkOutput("wr_ready_nocen", 32'(bus.wr_ready), 32'd0);

        // Free-running slot counter over 70 cens
        zeroCount = 0;
        for (int i = 0; i < 70; i++) begin
            idleTick();
            checkOutput("slot_count", 32'(slot_I), 32'(expSlot));
            checkOutput("zero_flag", 32'(zero), 32'(expSlot == 5'd0));
            checkOutput("idle_outputs", allOut(), 32'd0);
            if (zero) zeroCount++;
        end
        checkOutput("zero_pulses", 32'(zeroCount), 32'd2);

        repeat (6) @(negedge clk);
        checkOutput("cen_freeze", 32'(slot_I), 32'(expSlot));

        // Channel fields: high address bits ignored, data truncated
        writeReg(SEL_KC,  5'h1B, 7'h4A);
        writeReg(SEL_KF,  5'd3,  7'h55);
        writeReg(SEL_PMS, 5'd3,  7'h7D);
        writeReg(3'd6,    5'd3,  7'h7F);
        writeReg(3'd7,    5'd5,  7'h7F);
        for (int i = 0; i < 32; i++) begin
            idleTick();
            isCh3 = (expSlot[2:0] == 3'd3);
            checkOutput("kc_I", 32'(kc_I), isCh3 ? 32'h4A : 32'h0);
            checkOutput("kf_I", 32'(kf_I), isCh3 ? 32'h15 : 32'h0);
            checkOutput("pms_I", 32'(pms_I), isCh3 ? 32'h5 : 32'h0);
        end

        // Operator fields and their stage delays
        writeReg(SEL_MUL, 5'd5, 7'd7);
        writeReg(SEL_DT1, 5'd5, 7'd6);
        writeReg(SEL_DT2, 5'd5, 7'h7E);
        repeat (8) idleTick();
        for (int i = 0; i < 34; i++) begin
            idleTick();
            prevSlot = expSlot - 5'd1;
            mulSlot  = expSlot - 5'd5;
            checkOutput("dt2_I", 32'(dt2_I), (expSlot == 5'd5) ? 32'd2 : 32'd0);
            checkOutput("dt1_II", 32'(dt1_II), (prevSlot == 5'd5) ? 32'd6 : 32'd0);
            checkOutput("mul_VI", 32'(mul_VI), (mulSlot == 5'd5) ? 32'd7 : 32'd0);
        end

        // Key-on ch2 ops 0 and 2 -> slots 2 and 18, visible at slots 4 and 20
        advanceTo(5'd0);
        konReq(3'd2, 4'b0101);
        pulses = 0;
        for (int t = 1; t <= 70; t++) begin
            idleTick();
            checkOutput("kon_ch2_pulse", 32'(pg_rst_III), 32'((t == 3) || (t == 19)));
            if (pg_rst_III) pulses++;
        end
        checkOutput("kon_ch2_count", 32'(pulses), 32'd2);

        // Key-on landing on the slot being issued keeps the bit pending
        advanceTo(5'd20);
        konReq(3'd1, 4'b0001);
        advanceTo(5'd1);
        konReq(3'd1, 4'b0001);
        pulses = 0;
        for (int t = 1; t <= 66; t++) begin
            idleTick();
            checkOutput("kon_repeat_pulse", 32'(pg_rst_III), 32'((t == 1) || (t == 33)));
            if (pg_rst_III) pulses++;
        end
        checkOutput("kon_repeat_count", 32'(pulses), 32'd2);

        // Same collision, then cancel the repeat with ops=0
        advanceTo(5'd20);
        konReq(3'd1, 4'b0001);
        advanceTo(5'd1);
        konReq(3'd1, 4'b0001);
        for (int t = 1; t <= 45; t++) begin
            if (t == 10) konReq(3'd1, 4'b0000);
            else         idleTick();
            checkOutput("kon_cancel_pulse", 32'(pg_rst_III), 32'(t == 1));
        end

        // Reset mid-frame with key-ons still pending
        advanceTo(5'd10);
        konReq(3'd7, 4'b1111);
        advanceTo(5'd17);
        checkOutput("pre_rst_pulse", 32'(pg_rst_III), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_slot", 32'(slot_I), 32'd0);
        checkOutput("midrst_zero", 32'(zero), 32'd1);
        checkOutput("midrst_outputs", allOut(), 32'd0);
        checkOutput("midrst_wr_ready", 32'(bus.wr_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expSlot = 5'd0;
        for (int i = 0; i < 40; i++) begin
            idleTick();
            checkOutput("post_rst_slot", 32'(slot_I), 32'(expSlot));
            checkOutput("post_rst_outputs", allOut(), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/jt51_pg_sched.md
Name: jt51_pg_sched

Overview:
Per-slot parameter scheduler and register file for the JT51 phase generator (PG).
- Holds channel and operator frequency parameters.
- Runs the 32-slot time-multiplex counter.
- Presents each slot's parameters to the PG at the pipeline stage where the PG consumes them (I, II, VI).
- Turns CPU key-on requests into one phase-reset pulse per operator, aligned to PG stage III.
- Sits between the register-write front end and jt51_pg.

Parameters:
- NSLOT, 32, number of time slots; only 32 is supported.
- MUL_DLY, 5, cen cycles from stage I to stage VI for mul.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cen  in  1  clock enable; all state advances only when cen=1
- wr_valid  in  1  register write request
- wr_ready  out  1  write accepted this cycle
- wr_sel  in  3  target field: 0 kc, 1 kf, 2 pms, 3 mul, 4 dt1, 5 dt2, 6/7 reserved
- wr_addr  in  5  channel in [2:0] for kc/kf/pms; slot for mul/dt1/dt2
- wr_data  in  7  write data, LSB-aligned
- kon_valid  in  1  key-on request
- kon_ch  in  3  key-on channel
- kon_ops  in  4  operator mask, bit n = operator n
- zero  out  1  high when slot_I==0
- slot_I  out  5  current slot at stage I
- kc_I  out  7  key code, stage I
- kf_I  out  6  key fraction, stage I
- pms_I  out  3  PM sensitivity, stage I
- dt2_I  out  2  detune 2, stage I
- dt1_II  out  3  detune 1, stage II
- mul_VI  out  4  multiplier, stage VI
- pg_rst_III  out  1  phase reset, stage III

Behaviour:
- Slot mapping: slot = {op[1:0], ch[2:0]}.
  - Channel fields (kc, kf, pms) are indexed by slot_I[2:0].
  - Operator fields (mul, dt1, dt2) are indexed by slot_I.
- slot_I: 5-bit register, +1 on each cen, wraps 31->0; zero = (slot_I==0).
- Register files: 8x kc/kf/pms and 32x mul/dt1/dt2, held in flops.
  - Stage-I outputs are combinational reads at slot_I.
- Delayed outputs: dt1_II, pg_rst_III and mul_VI are produced by shift registers clocked on cen, with depths 1, 2 and MUL_DLY.
  - Each delayed output equals the value the addressed slot held at its stage I.
- Reset values: slot_I=0, so zero=1 out of reset.
  - All register-file entries, pending mask and delay lines clear to 0.
  - Hence every data output is 0, pg_rst_III=0 and wr_ready=0 while rst=1.
- Write handshake: wr_ready = cen & ~rst.
  - Accept on wr_valid & wr_ready.
  - wr_data is truncated to the field width.
  - Reserved wr_sel values are accepted and ignored.
  - For kc/kf/pms, wr_addr[4:3] is ignored.
  - A write to the slot currently at stage I: the old value is output this cycle, the new value from the next visit.
- Key-on, 32-bit pending mask. On an accepted kon (cen=1), the pending bits for {op,kon_ch} become kon_ops[op]; kon_ops=0 cancels the channel.
- Issue: on cen, if pending[slot_I] is set, a 1 enters the pg_rst delay line and the bit clears.
  - If kon sets the same bit in that cycle, the set wins: the pulse is issued now and the bit stays pending, firing again 32 cens later.
- cen=0 freezes every register; outputs hold.
- Reset mid-operation: immediate return to reset values; pending key-ons are lost.

Decomposition:
- Shared package jt51_pg_pkg:
  - field-select constants (SEL_KC..SEL_DT2);
  - slot/channel/op width constants;
  - NSLOT;
  - stage-offset constants (DT1_DLY=1, RST_DLY=2, MUL_DLY=5).
- Delay lines reuse the existing jt51_sh shift register (widths 3, 1, 4). No new sub-module.

Test Plan:
- Reset, then 70 cens with cen toggled every other clk: zero pulses on slot_I 0→31→0 every 32 cens; all data outputs stay 0; wr_ready=0 during rst.
- Write kc ch3 = 0x4A and kf ch3 = 0x15: kc_I=0x4A and kf_I=0x15 at slot_I 3, 11, 19, 27; all other slots read 0.
- Write mul slot 5 = 7 and dt1 slot 5 = 6: dt1_II=6 one cen after slot_I=5; mul_VI=7 exactly five cens after; both 0 elsewhere.
- kon ch2, ops=4'b0101, issued while slot_I=0: pg_rst_III=1 two cens after slot_I=2 and two cens after slot_I=18; no further pulses over 64 cens.
- kon ch1, ops=1 accepted in the cen where slot_I=1 and bit already pending: pulse now and again 32 cens later. Then kon ch1, ops=0 before the repeat: repeat is suppressed.
- Assert rst mid-frame at slot_I=17 with pending key-ons: immediate slot_I=0, outputs 0, no pg_rst_III after release.
